// File: rtl/sdc_pkg.sv
// sdc_pkg: definitions shared by the sample-dump/sample-player blocks.
//   - ASCII constants for the command letters and line terminators
//   - player_state_t: top-level player FSM states
//   - hex_to_nibble: ASCII hex digit -> {valid, nibble}
//   - is_cmd: case-insensitive match of a byte against an upper-case letter
package sdc_pkg;

    localparam logic [7:0] CHAR_L  = 8'h4C;
    localparam logic [7:0] CHAR_P  = 8'h50;
    localparam logic [7:0] CHAR_S  = 8'h53;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } player_state_t;

    // Bit 4 flags a valid digit. Letters A-F and a-f share the same low
    // nibble (1..6), so adding 9 yields 10..15 for either case.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] res;
        res = 5'b0;
        if (c >= "0" && c <= "9") begin
            res = {1'b1, c[3:0]};
        end else if ((c >= "A" && c <= "F") || (c >= "a" && c <= "f")) begin
            res = {1'b1, c[3:0] + 4'd9};
        end
        return res;
    endfunction

    // ASCII lower case differs from upper case only in bit 5.
    function automatic logic is_cmd(input logic [7:0] c, input logic [7:0] upper);
        return (c == upper) || (c == (upper | 8'h20));
    endfunction

endpackage

// File: rtl/hex_line_parser.sv
// hex_line_parser: turns a stream of ASCII bytes into fixed-width words, one
// per LF-terminated line of exactly WORD_BITS/4 hex digits (MSB nibble first).
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   clear            drop any partial line and leave suppress mode
//   in_valid/in_byte byte strobe and data
//   word             assembled word; valid in the cycle word_valid is high
//   word_valid       one-cycle pulse, line committed
//   line_err         one-cycle pulse, line rejected
// All outputs appear one cycle after the byte that causes them.
module hex_line_parser
    import sdc_pkg::*;
#(
    parameter int WORD_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_valid,
    output logic                 line_err
);

    localparam int NUM_DIGITS = WORD_BITS / 4;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(NUM_DIGITS + 1);

    logic [CNT_W-1:0] digit_cnt;
    logic             suppress;
    logic [4:0]       nib;

    assign nib = hex_to_nibble(in_byte);

    // The digit counter saturates one past a full line so that overlong
    // lines are still rejected at LF. The shift register is not cleared
    // between lines: only the last NUM_DIGITS digits survive anyway, and a
    // line is committed only when exactly that many arrived.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            word       <= '0;
            digit_cnt  <= '0;
            suppress   <= 1'b0;
            word_valid <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            line_err   <= 1'b0;
            if (in_valid) begin
                if (suppress) begin
                    // A bad byte already counted this line; its LF only resyncs.
                    if (in_byte == CHAR_LF) begin
                        suppress  <= 1'b0;
                        digit_cnt <= '0;
                    end
                end else if (nib[4]) begin
                    word <= {word[WORD_BITS-5:0], nib[3:0]};
                    if (digit_cnt != CNT_OVER) begin
                        digit_cnt <= digit_cnt + 1'b1;
                    end
                end else if (in_byte == CHAR_LF) begin
                    digit_cnt <= '0;
                    if (digit_cnt == CNT_FULL) begin
                        word_valid <= 1'b1;
                    end else begin
                        line_err <= 1'b1;
                    end
                end else if (in_byte != CHAR_CR) begin
                    line_err  <= 1'b1;
                    suppress  <= 1'b1;
                    digit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/hex_sample_player.sv
// hex_sample_player: loads ASCII-hex sample lines from the UART RX stream
// into a sample RAM and plays them out to the sigma-delta DAC input.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   rvalid, rdata, rready UART RX byte handshake (byte taken on rvalid & rready)
//   dac_data, dac_valid   sample to the DAC, held until dac_ready
//   dac_ready             DAC sample-rate strobe
//   loaded                RAM holds a complete NUM_SAMPLES set
//   playing               FSM is in PLAY
//   err_count             saturating count of rejected lines
// Commands in IDLE: L/l load, P/p play (only when loaded). S/s stops playback.
module hex_sample_player
    import sdc_pkg::*;
#(
    parameter int NUM_SAMPLES   = 1024,
    parameter int DAC_BITLEN    = 24,
    parameter int SIGNED_OUTPUT = 0,
    parameter int LOOP          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rvalid,
    input  logic [7:0]            rdata,
    output logic                  rready,
    output logic [DAC_BITLEN-1:0] dac_data,
    output logic                  dac_valid,
    input  logic                  dac_ready,
    output logic                  loaded,
    output logic                  playing,
    output logic [15:0]           err_count
);

    localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
    // Flipping the MSB converts offset-binary RAM contents to two's complement.
    localparam logic [DAC_BITLEN-1:0] MSB_FLIP =
        (SIGNED_OUTPUT != 0) ? {1'b1, {(DAC_BITLEN-1){1'b0}}} : '0;

    player_state_t state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             fetch_wait;

    logic                  rx_take;
    logic                  parser_clear;
    logic [DAC_BITLEN-1:0] line_word;
    logic                  word_valid;
    logic                  line_err;

    logic [DAC_BITLEN-1:0] mem [NUM_SAMPLES];
    logic [DAC_BITLEN-1:0] ram_q;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_addr;

    assign rx_take      = rvalid & rready;
    assign parser_clear = rx_take && (state == IDLE) && is_cmd(rdata, CHAR_L);

    hex_line_parser #(
        .WORD_BITS (DAC_BITLEN)
    ) u_parser (
        .clk        (clk),
        .rst        (rst),
        .clear      (parser_clear),
        .in_valid   (rx_take && (state == LOAD)),
        .in_byte    (rdata),
        .word       (line_word),
        .word_valid (word_valid),
        .line_err   (line_err)
    );

    // Single-port RAM: the write port is only used in LOAD, so the address
    // can follow the read index everywhere else.
    assign ram_we   = word_valid && (state == LOAD);
    assign ram_addr = (state == LOAD) ? wr_idx : rd_idx;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= line_word;
        end
        ram_q <= mem[ram_addr];
    end

    // fetch_wait covers the RAM read latency: after PLAY entry or an accepted
    // sample the new rd_idx is presented for one cycle, then ram_q is latched
    // into dac_data, so dac_valid rises two cycles later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rready     <= 1'b0;
            dac_valid  <= 1'b0;
            dac_data   <= '0;
            loaded     <= 1'b0;
            playing    <= 1'b0;
            err_count  <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            fetch_wait <= 1'b0;
        end else begin
            rready <= 1'b1;

            if (line_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rx_take) begin
                        if (is_cmd(rdata, CHAR_L)) begin
                            state  <= LOAD;
                            loaded <= 1'b0;
                            wr_idx <= '0;
                        end else if (is_cmd(rdata, CHAR_P) && loaded) begin
                            state      <= PLAY;
                            playing    <= 1'b1;
                            rd_idx     <= '0;
                            dac_valid  <= 1'b0;
                            fetch_wait <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (word_valid) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == LAST_IDX) begin
                            loaded <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end

                PLAY: begin
                    if (dac_valid && dac_ready) begin
                        dac_valid  <= 1'b0;
                        fetch_wait <= 1'b1;
                        if (rd_idx == LAST_IDX) begin
                            rd_idx <= '0;
                            if (LOOP == 0) begin
                                state   <= IDLE;
                                playing <= 1'b0;
                            end
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end else if (!dac_valid) begin
                        if (fetch_wait) begin
                            fetch_wait <= 1'b0;
                        end else begin
                            dac_valid <= 1'b1;
                            dac_data  <= ram_q ^ MSB_FLIP;
                        end
                    end

                    // Stop overrides everything above; dac_data keeps its value.
                    if (rx_take && is_cmd(rdata, CHAR_S)) begin
                        state     <= IDLE;
                        playing   <= 1'b0;
                        dac_valid <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_sample_player.sv
// tb_hex_sample_player: directed bench for hex_sample_player.
// Instance a: NUM_SAMPLES=4, unsigned output, single pass.
// Instance b: NUM_SAMPLES=4, signed output, looping playback.
// Both share clock, reset and rdata; each has its own rvalid and dac_ready.
module tb_hex_sample_player;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rdata;
    logic        rvalid_a, rvalid_b;
    logic        dac_ready_a, dac_ready_b;

    logic        rready_a, rready_b;
    logic [23:0] dac_data_a, dac_data_b;
    logic        dac_valid_a, dac_valid_b;
    logic        loaded_a, loaded_b;
    logic        playing_a, playing_b;
    logic [15:0] err_count_a, err_count_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hex_sample_player #(
        .NUM_SAMPLES(4), .DAC_BITLEN(24), .SIGNED_OUTPUT(0), .LOOP(0)
    ) dut_a (
        .clk(clk), .rst(rst), .rvalid(rvalid_a), .rdata(rdata), .rready(rready_a),
        .dac_data(dac_data_a), .dac_valid(dac_valid_a), .dac_ready(dac_ready_a),
        .loaded(loaded_a), .playing(playing_a), .err_count(err_count_a)
    );

    hex_sample_player #(
        .NUM_SAMPLES(4), .DAC_BITLEN(24), .SIGNED_OUTPUT(1), .LOOP(1)
    ) dut_b (
        .clk(clk), .rst(rst), .rvalid(rvalid_b), .rdata(rdata), .rready(rready_b),
        .dac_data(dac_data_b), .dac_valid(dac_valid_b), .dac_ready(dac_ready_b),
        .loaded(loaded_b), .playing(playing_b), .err_count(err_count_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Sends each character of s as one byte per cycle to the selected instance.
    task automatic applyStimulus(input int sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            rdata = s[i];
            if (sel == 0) rvalid_a = 1'b1;
            else          rvalid_b = 1'b1;
            @(posedge clk);
            #1;
            rvalid_a = 1'b0;
            rvalid_b = 1'b0;
        end
    endtask

    function automatic logic getValid(input int sel);
        return (sel == 0) ? dac_valid_a : dac_valid_b;
    endfunction

    function automatic logic [23:0] getData(input int sel);
        return (sel == 0) ? dac_data_a : dac_data_b;
    endfunction

    // Waits (bounded) for dac_valid; cycles reports how many edges it took.
    task automatic waitValid(input int sel, output int cycles);
        cycles = 0;
        while (!getValid(sel) && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Must be called one step after PLAY entry or after the previous accept.
    task automatic playSample(input int sel, input logic [23:0] exp, input string tag);
        int cyc;
        waitValid(sel, cyc);
        checkOutput({tag, "_lat"}, 32'(cyc), 32'd2);
        checkOutput(tag, 32'(getData(sel)), 32'(exp));
        if (sel == 0) dac_ready_a = 1'b1;
        else          dac_ready_b = 1'b1;
        @(posedge clk);
        #1;
        dac_ready_a = 1'b0;
        dac_ready_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] held;
        logic        stable;
        logic        v, r;
        logic [23:0] d;
        logic [23:0] exp_r [4];
        int          cyc;
        int          k;
        int          guard;

        rst = 1'b0;
        rdata = 8'h00;
        rvalid_a = 1'b0;
        rvalid_b = 1'b0;
        dac_ready_a = 1'b0;
        dac_ready_b = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rready", 32'(rready_a), 32'd0);
        checkOutput("rst_dac_valid", 32'(dac_valid_a), 32'd0);
        checkOutput("rst_dac_data", 32'(dac_data_a), 32'd0);
        checkOutput("rst_loaded", 32'(loaded_a), 32'd0);
        checkOutput("rst_err", 32'(err_count_a), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rready_up", 32'(rready_a), 32'd1);

        // Play before any load is ignored
        applyStimulus(0, "P");
        checkOutput("p_unloaded_playing", 32'(playing_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("p_unloaded_valid", 32'(dac_valid_a), 32'd0);

        // Basic load, CR tolerated
        applyStimulus(0, "L");
        applyStimulus(0, "00000A\015\n123456\n");
        checkOutput("load_partial", 32'(loaded_a), 32'd0);
        applyStimulus(0, "FFFFFF\n800000\n");
        @(posedge clk);
        #1;
        checkOutput("load_done", 32'(loaded_a), 32'd1);
        checkOutput("load_err", 32'(err_count_a), 32'd0);
        checkOutput("load_idle", 32'(playing_a), 32'd0);

        // Playback, including a 50-cycle stall on sample 2
        applyStimulus(0, "P");
        checkOutput("play_entry", 32'(playing_a), 32'd1);
        playSample(0, 24'h00000A, "a_s0");
        playSample(0, 24'h123456, "a_s1");
        waitValid(0, cyc);
        checkOutput("a_s2_lat", 32'(cyc), 32'd2);
        held = dac_data_a;
        stable = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (!dac_valid_a || dac_data_a !== held) stable = 1'b0;
        end
        checkOutput("hold_stable", 32'(stable), 32'd1);
        checkOutput("a_s2", 32'(held), 32'hFFFFFF);
        dac_ready_a = 1'b1;
        @(posedge clk);
        #1;
        dac_ready_a = 1'b0;
        playSample(0, 24'h800000, "a_s3");
        checkOutput("a_end_playing", 32'(playing_a), 32'd0);
        checkOutput("a_end_valid", 32'(dac_valid_a), 32'd0);
        checkOutput("a_end_loaded", 32'(loaded_a), 32'd1);

        // Lower-case and rejected lines
        applyStimulus(0, "l");
        applyStimulus(0, "abcdef\n");
        applyStimulus(0, "123\n12G456\n\n");
        @(posedge clk);
        #1;
        checkOutput("err_three", 32'(err_count_a), 32'd3);
        checkOutput("err_not_loaded", 32'(loaded_a), 32'd0);
        applyStimulus(0, "000001\n000002\n000003\n");
        @(posedge clk);
        #1;
        checkOutput("err_reload_done", 32'(loaded_a), 32'd1);
        checkOutput("err_still_three", 32'(err_count_a), 32'd3);

        // Random dac_ready: every sample exactly once, in order
        exp_r[0] = 24'hABCDEF;
        exp_r[1] = 24'h000001;
        exp_r[2] = 24'h000002;
        exp_r[3] = 24'h000003;
        applyStimulus(0, "p");
        k = 0;
        guard = 0;
        while (k < 4 && guard < 400) begin
            v = dac_valid_a;
            d = dac_data_a;
            r = 1'($urandom_range(0, 1));
            dac_ready_a = r;
            @(posedge clk);
            #1;
            guard++;
            if (v && r) begin
                checkOutput($sformatf("rnd_s%0d", k), 32'(d), 32'(exp_r[k]));
                k++;
            end
        end
        dac_ready_a = 1'b0;
        checkOutput("rnd_count", 32'(k), 32'd4);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rnd_no_repeat", 32'(dac_valid_a), 32'd0);
        checkOutput("rnd_playing", 32'(playing_a), 32'd0);

        // Reset in the middle of a load
        applyStimulus(0, "L111111\n222222\n");
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_loaded", 32'(loaded_a), 32'd0);
        checkOutput("midrst_err", 32'(err_count_a), 32'd0);
        checkOutput("midrst_playing", 32'(playing_a), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, "L0000AA\n0000BB\n0000CC\n0000DD\n");
        @(posedge clk);
        #1;
        checkOutput("after_rst_loaded", 32'(loaded_a), 32'd1);
        applyStimulus(0, "P");
        playSample(0, 24'h0000AA, "after_rst_s0");
        playSample(0, 24'h0000BB, "after_rst_s1");

        // Instance b: signed output and looping
        applyStimulus(1, "L800000\n000001\n7FFFFF\n123456\n");
        @(posedge clk);
        #1;
        checkOutput("b_loaded", 32'(loaded_b), 32'd1);
        applyStimulus(1, "P");
        playSample(1, 24'h000000, "b_s0");
        playSample(1, 24'h800001, "b_s1");
        playSample(1, 24'hFFFFFF, "b_s2");
        playSample(1, 24'h923456, "b_s3");
        checkOutput("b_loop_playing", 32'(playing_b), 32'd1);
        playSample(1, 24'h000000, "b_wrap");

        // Stop while a sample is pending
        waitValid(1, cyc);
        checkOutput("b_pend_valid", 32'(dac_valid_b), 32'd1);
        applyStimulus(1, "S");
        checkOutput("b_stop_valid", 32'(dac_valid_b), 32'd0);
        checkOutput("b_stop_playing", 32'(playing_b), 32'd0);
        checkOutput("b_stop_data_held", 32'(dac_data_b), 32'h800001);

        // Stop coincident with dac_ready
        applyStimulus(1, "p");
        waitValid(1, cyc);
        checkOutput("b_co_data", 32'(dac_data_b), 32'h000000);
        rdata = "s";
        rvalid_b = 1'b1;
        dac_ready_b = 1'b1;
        @(posedge clk);
        #1;
        rvalid_b = 1'b0;
        dac_ready_b = 1'b0;
        checkOutput("b_co_playing", 32'(playing_b), 32'd0);
        checkOutput("b_co_valid", 32'(dac_valid_b), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("b_co_stays_idle", 32'(dac_valid_b), 32'd0);
        applyStimulus(1, "P");
        playSample(1, 24'h000000, "b_restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
